ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 25 ++
 rtl/ps2_line_filter.sv | 51 +++++
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: FSM state encoding,
// default timing constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  localparam int unsigned DEF_INHIBIT_CYCLES = 420;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 52500;
  localparam int unsigned DEF_FILTER_LEN     = 4;

  // The parity bit makes the total number of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output only changes
// once FILTER_LEN consecutive synchronized samples agree on the new level.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clk,
  input  logic nreset,
  input  logic i_line,
  output logic o_line
);

  logic [1:0]            r_sync;
  logic [FILTER_LEN-1:0] r_hist;
  logic [FILTER_LEN-1:0] w_hist_next;
  logic                  r_line;
  logic                  w_all_high;
  logic                  w_all_low;

  for (genvar gi = 0; gi < FILTER_LEN; gi++) begin : g_hist
    if (gi == 0) begin : g_head
      assign w_hist_next[gi] = r_sync[1];
    end else begin : g_tail
      assign w_hist_next[gi] = r_hist[gi-1];
    end
  end

  assign w_all_high = &r_hist;
  assign w_all_low  = ~|r_hist;

  // Idle PS/2 lines float high, so everything presets to 1.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_sync <= '1;
      r_hist <= '1;
      r_line <= 1'b1;
    end else begin
      r_sync <= {r_sync[0], i_line};
      r_hist <= w_hist_next;
      if (w_all_high) begin
        r_line <= 1'b1;
      end else if (w_all_low) begin
        r_line <= 1'b0;
      end
    end
  end

  assign o_line = r_line;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, request-to-send, 8 data bits,
// odd parity, stop, device ACK). Optional watchdog: PS2_HOST_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned      INH_W    = $clog2(INHIBIT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  ps2_tx_state_e    r_state;
  ps2_tx_state_e    w_state_next;
  logic [7:0]       r_data;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [INH_W-1:0] r_inh_cnt;
  logic [INH_W-1:0] w_inh_cnt_next;
  logic             r_clk_prev;
  logic             r_clk_oe;
  logic             r_dat_oe;
  logic             r_tx_done;
  logic             r_tx_error;
  logic             w_clk_oe_next;
  logic             w_dat_oe_next;
  logic             w_done_next;
  logic             w_error_next;
  logic             w_load;
  logic             w_clk_filt;
  logic             w_dat_filt;
  logic             w_clk_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk    (clk),
    .nreset (nreset),
    .i_line (ps2_clk_in),
    .o_line (w_clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk    (clk),
    .nreset (nreset),
    .i_line (ps2_dat_in),
    .o_line (w_dat_filt)
  );

  assign w_clk_fall = r_clk_prev & ~w_clk_filt;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_in_window;
  logic            w_timeout;

  // Counts only while waiting on the device; INHIBIT keeps it at zero so it
  // starts fresh the cycle the clock line is released.
  assign w_in_window = (r_state inside {ST_REQ, ST_DATA, ST_PARITY, ST_STOP, ST_ACK});
  assign w_timeout   = w_in_window && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!nreset || !w_in_window) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end
`endif

  always_comb begin
    w_state_next   = r_state;
    w_bit_idx_next = r_bit_idx;
    w_inh_cnt_next = r_inh_cnt;
    w_done_next    = 1'b0;
    w_error_next   = 1'b0;
    w_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid) begin
          w_load         = 1'b1;
          w_inh_cnt_next = '0;
          w_state_next   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_inh_cnt == INH_LAST) begin
          w_state_next = ST_REQ;
        end else begin
          w_inh_cnt_next = r_inh_cnt + INH_W'(1);
        end
      end
      ST_REQ: begin
        if (w_clk_fall) begin
          w_bit_idx_next = '0;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_clk_fall) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next = ST_PARITY;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (w_clk_fall) begin
          w_state_next = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_clk_fall) begin
          w_state_next = ST_ACK;
        end
      end
      // Entered on the falling edge after stop; the device holds its ACK
      // level for the whole low phase, so one look is enough.
      ST_ACK: begin
        if (!w_dat_filt) begin
          w_state_next = ST_WAIT_IDLE;
        end else begin
          w_error_next = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_filt && w_dat_filt) begin
          w_done_next  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
`ifdef PS2_HOST_TX_TIMEOUT_EN
    if (w_timeout) begin
      w_done_next  = 1'b0;
      w_error_next = 1'b1;
      w_state_next = ST_IDLE;
    end
`endif
  end

  // Line drives are registered from next-state values so the open-drain
  // enables never glitch on state decode.
  always_comb begin
    w_clk_oe_next = (w_state_next == ST_INHIBIT);
    w_dat_oe_next = 1'b0;
    case (w_state_next)
      ST_INHIBIT: w_dat_oe_next = (w_inh_cnt_next == INH_LAST);
      ST_REQ:     w_dat_oe_next = 1'b1;
      ST_DATA:    w_dat_oe_next = ~r_data[w_bit_idx_next];
      ST_PARITY:  w_dat_oe_next = ~odd_parity(r_data);
      default:    w_dat_oe_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_inh_cnt  <= '0;
      r_clk_prev <= 1'b1;
      r_clk_oe   <= 1'b0;
      r_dat_oe   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_error <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_idx  <= w_bit_idx_next;
      r_inh_cnt  <= w_inh_cnt_next;
      r_clk_prev <= w_clk_filt;
      r_clk_oe   <= w_clk_oe_next;
      r_dat_oe   <= w_dat_oe_next;
      r_tx_done  <= w_done_next;
      r_tx_error <= w_error_next;
      if (w_load) begin
        r_data <= tx_data;
      end
    end
  end

  assign tx_ready   = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign ps2_clk_oe = r_clk_oe;
  assign ps2_dat_oe = r_dat_oe;
  assign tx_done    = r_tx_done;
  assign tx_error   = r_tx_error;

endmodule
